// File: rtl/ssp_slv_os.sv
// Oversampled SSP/SPI slave for {address, WnR, data} frames, MSB first.
// All serial inputs are resynchronised into Clk, so every output is Clk-synchronous.
module ssp_slv_os #(
    parameter int pAW  = 3,
    parameter int pDW  = 12,
    parameter int pBCW = 5
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic            SSEL,
    input  logic            SCK,
    input  logic            MOSI,
    output logic            MISO,
    output logic            MISO_OE,
    output logic [pAW-1:0]  RA,
    output logic            WnR,
    output logic            En,
    output logic            Rd,
    input  logic [pDW-1:0]  DO,
    output logic            Wr,
    output logic [pDW-1:0]  DI,
    output logic            EOC,
    output logic            FrmErr,
    output logic [pBCW-1:0] BC
);

    localparam int N = pAW + 1 + pDW;
    localparam logic [pBCW-1:0] LP_BC_ZERO = {pBCW{1'b0}};
    localparam logic [pBCW-1:0] LP_BC_ONE  = {{(pBCW-1){1'b0}}, 1'b1};
    localparam logic [pBCW-1:0] LP_BC_ADDR = pBCW'(pAW);
    localparam logic [pBCW-1:0] LP_BC_HDR  = pBCW'(pAW + 1);
    localparam logic [pBCW-1:0] LP_BC_N    = pBCW'(N);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic r_ssel_m, r_ssel_s, r_ssel_d;
    logic r_sck_m, r_sck_s, r_sck_d;
    logic r_mosi_m, r_mosi_s;
    logic [1:0] r_fill;
    logic r_armed;

    logic [N-1:0]    r_sr;
    logic [pBCW-1:0] r_bc;
    logic [pDW-1:0]  r_rdo;
    logic            r_samp_d;
    logic            r_rd_d;

    logic            r_miso;
    logic            r_miso_oe;
    logic [pAW-1:0]  r_ra;
    logic            r_wnr;
    logic            r_en;
    logic            r_rd;
    logic            r_wr;
    logic [pDW-1:0]  r_di;
    logic            r_eoc;
    logic            r_frmerr;

    logic w_ssel_rise, w_ssel_fall, w_sck_rise, w_sck_fall;
    logic w_active, w_start, w_frm_end, w_sample, w_drive;
    logic w_bc_data, w_bc_short;

    // Two-stage synchronisers, an edge-detect stage, and arming once SSEL is genuinely seen low.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ssel_m <= 1'b0;
            r_ssel_s <= 1'b0;
            r_ssel_d <= 1'b0;
            r_sck_m  <= 1'b0;
            r_sck_s  <= 1'b0;
            r_sck_d  <= 1'b0;
            r_mosi_m <= 1'b0;
            r_mosi_s <= 1'b0;
            r_fill   <= 2'd0;
            r_armed  <= 1'b0;
        end else begin
            r_ssel_m <= SSEL;
            r_ssel_s <= r_ssel_m;
            r_ssel_d <= r_ssel_s;
            r_sck_m  <= SCK;
            r_sck_s  <= r_sck_m;
            r_sck_d  <= r_sck_s;
            r_mosi_m <= MOSI;
            r_mosi_s <= r_mosi_m;
            // r_fill gates arming until the cleared synchroniser holds a real sample of SSEL
            if (r_fill != 2'd2) begin
                r_fill <= r_fill + 2'd1;
            end
            if ((r_fill == 2'd2) && !r_ssel_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Edge events and per-cycle frame actions; frame start outranks frame end outranks SCK work.
    always_comb begin
        w_ssel_rise = r_ssel_s & ~r_ssel_d;
        w_ssel_fall = ~r_ssel_s & r_ssel_d;
        w_sck_rise  = r_sck_s & ~r_sck_d;
        w_sck_fall  = ~r_sck_s & r_sck_d;
        w_active    = (r_state == ST_ACTIVE);
        w_start     = w_ssel_rise & r_armed;
        w_frm_end   = w_ssel_fall & w_active & ~w_start;
        w_sample    = w_sck_rise & w_active & ~w_start & ~w_ssel_fall & (r_bc < LP_BC_N);
        w_drive     = w_sck_fall & w_active & ~w_start & ~w_ssel_fall;
        w_bc_data   = (r_bc >= LP_BC_HDR) && (r_bc < LP_BC_N);
        w_bc_short  = (r_bc != LP_BC_ZERO) && (r_bc < LP_BC_N);
    end

    // Frame state register.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Frame next-state: enter on an honoured SSEL rise, leave on an SSEL fall.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_nxt = ST_ACTIVE;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (w_start) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_ssel_fall) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Serial datapath: shift in on SCK rise, shift read data out on SCK fall.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sr     <= {N{1'b0}};
            r_bc     <= LP_BC_ZERO;
            r_rdo    <= {pDW{1'b0}};
            r_miso   <= 1'b0;
            r_samp_d <= 1'b0;
        end else begin
            r_samp_d <= w_sample;
            if (w_start) begin
                r_sr   <= {N{1'b0}};
                r_bc   <= LP_BC_ZERO;
                r_miso <= 1'b0;
            end else if (w_frm_end) begin
                r_miso <= 1'b0;
            end else begin
                if (w_sample) begin
                    r_sr <= {r_sr[N-2:0], r_mosi_s};
                    r_bc <= r_bc + LP_BC_ONE;
                end
                if (w_drive) begin
                    r_miso <= w_bc_data ? r_rdo[pDW-1] : 1'b0;
                end
            end
            // The read-data capture never coincides with a data-phase falling edge.
            if (r_rd_d) begin
                r_rdo <= DO;
            end else if (w_drive && w_bc_data) begin
                r_rdo <= r_rdo << 1'b1;
            end
        end
    end

    // Register-file side: header decode, strobes, completion and frame-error reporting.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ra      <= {pAW{1'b0}};
            r_wnr     <= 1'b0;
            r_en      <= 1'b0;
            r_rd      <= 1'b0;
            r_rd_d    <= 1'b0;
            r_wr      <= 1'b0;
            r_di      <= {pDW{1'b0}};
            r_eoc     <= 1'b0;
            r_frmerr  <= 1'b0;
            r_miso_oe <= 1'b0;
        end else begin
            r_rd      <= 1'b0;
            r_wr      <= 1'b0;
            r_eoc     <= 1'b0;
            r_frmerr  <= 1'b0;
            r_rd_d    <= r_rd;
            r_miso_oe <= r_ssel_s & r_armed;
            if (w_frm_end) begin
                r_en     <= 1'b0;
                r_frmerr <= w_bc_short;
            end else if (r_samp_d && w_active) begin
                if (r_bc == LP_BC_ADDR) begin
                    r_ra <= r_sr[pAW-1:0];
                end
                if (r_bc == LP_BC_HDR) begin
                    r_wnr <= r_sr[0];
                    r_en  <= 1'b1;
                    r_rd  <= 1'b1;
                end
                if (r_bc == LP_BC_N) begin
                    r_di  <= r_sr[pDW-1:0];
                    r_eoc <= 1'b1;
                    r_wr  <= r_wnr;
                end
            end
        end
    end

    assign MISO    = r_miso;
    assign MISO_OE = r_miso_oe;
    assign RA      = r_ra;
    assign WnR     = r_wnr;
    assign En      = r_en;
    assign Rd      = r_rd;
    assign Wr      = r_wr;
    assign DI      = r_di;
    assign EOC     = r_eoc;
    assign FrmErr  = r_frmerr;
    assign BC      = r_bc;

endmodule

// File: tb/tb_ssp_slv_os.sv
// Bench for ssp_slv_os: directed and random frames on a default and a widened instance,
// checked against a frame-level model of the expected strobes, decoded fields and MISO bits.
module tb_ssp_slv_os;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Rst, ssel, SCK, MOSI;
    bit   sel;
    logic SSEL_a, SSEL_b;
    assign SSEL_a = ssel & ~sel;
    assign SSEL_b = ssel & sel;

    logic a_miso, a_oe, a_wnr, a_en, a_rd, a_wr, a_eoc, a_ferr;
    logic [2:0]  a_ra;
    logic [11:0] a_di, DO_a;
    logic [4:0]  a_bc;
    logic b_miso, b_oe, b_wnr, b_en, b_rd, b_wr, b_eoc, b_ferr;
    logic [3:0]  b_ra;
    logic [15:0] b_di, DO_b;
    logic [4:0]  b_bc;

    ssp_slv_os #(.pAW(3), .pDW(12), .pBCW(5)) dut_a (
        .Clk(Clk), .Rst(Rst), .SSEL(SSEL_a), .SCK(SCK), .MOSI(MOSI),
        .MISO(a_miso), .MISO_OE(a_oe), .RA(a_ra), .WnR(a_wnr), .En(a_en),
        .Rd(a_rd), .DO(DO_a), .Wr(a_wr), .DI(a_di), .EOC(a_eoc),
        .FrmErr(a_ferr), .BC(a_bc));

    ssp_slv_os #(.pAW(4), .pDW(16), .pBCW(5)) dut_b (
        .Clk(Clk), .Rst(Rst), .SSEL(SSEL_b), .SCK(SCK), .MOSI(MOSI),
        .MISO(b_miso), .MISO_OE(b_oe), .RA(b_ra), .WnR(b_wnr), .En(b_en),
        .Rd(b_rd), .DO(DO_b), .Wr(b_wr), .DI(b_di), .EOC(b_eoc),
        .FrmErr(b_ferr), .BC(b_bc));

    logic m_miso, m_oe, m_wnr, m_en, m_rd, m_wr, m_eoc, m_ferr;
    logic [3:0]  m_ra;
    logic [15:0] m_di;
    logic [4:0]  m_bc;
    assign m_miso = sel ? b_miso : a_miso;
    assign m_oe   = sel ? b_oe   : a_oe;
    assign m_wnr  = sel ? b_wnr  : a_wnr;
    assign m_en   = sel ? b_en   : a_en;
    assign m_rd   = sel ? b_rd   : a_rd;
    assign m_wr   = sel ? b_wr   : a_wr;
    assign m_eoc  = sel ? b_eoc  : a_eoc;
    assign m_ferr = sel ? b_ferr : a_ferr;
    assign m_ra   = sel ? b_ra   : {1'b0, a_ra};
    assign m_di   = sel ? b_di   : {4'd0, a_di};
    assign m_bc   = sel ? b_bc   : a_bc;

    int total = 0;
    int bad = 0;
    int n_eoc = 0, n_wr = 0, n_rd = 0, n_ferr = 0, n_wr_alone = 0;

    // Pulse counters for the selected instance.
    always @(negedge Clk) begin
        if (m_eoc) n_eoc++;
        if (m_wr) n_wr++;
        if (m_rd) n_rd++;
        if (m_ferr) n_ferr++;
        if (m_wr && !m_eoc) n_wr_alone++;
    end

    // Register-file read model: DO carries the read value only in the Clk after Rd.
    logic [15:0] do_val = 16'd0;
    bit rd_prev;
    initial begin
        DO_a = 12'd0;
        DO_b = 16'd0;
        rd_prev = 1'b0;
        forever begin
            @(posedge Clk);
            #1;
            if (rd_prev) begin
                DO_a = do_val[11:0];
                DO_b = do_val;
            end else begin
                DO_a = 12'($urandom);
                DO_b = 16'($urandom);
            end
            rd_prev = m_rd;
        end
    end

    logic [15:0] di_m [2];
    logic [3:0]  ra_m [2];
    logic        wnr_m [2];

    task automatic clks(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input bit s, input int nclk, input logic [3:0] addr_i, input bit wnr,
                         input logic [15:0] data_i, input logic [15:0] dov_i);
        int aw, dw, n, b_eoc, b_wr, b_rd, b_ferr, b_wa;
        logic [3:0]  addr;
        logic [15:0] data, dov;
        logic [31:0] fv, miso_obs, miso_exp;
        logic en_obs, oe_obs;
        bit complete;
        aw = s ? 4 : 3;
        dw = s ? 16 : 12;
        n = aw + 1 + dw;
        addr = s ? addr_i : {1'b0, addr_i[2:0]};
        data = s ? data_i : {4'd0, data_i[11:0]};
        dov  = s ? dov_i  : {4'd0, dov_i[11:0]};
        fv = ({28'd0, addr} << (1 + dw)) | ({31'd0, wnr} << dw) | {16'd0, data};
        sel = s;
        do_val = dov;
        miso_obs = 32'd0;
        miso_exp = 32'd0;
        oe_obs = 1'b0;
        b_eoc = n_eoc; b_wr = n_wr; b_rd = n_rd; b_ferr = n_ferr; b_wa = n_wr_alone;
        clks(2);
        ssel = 1'b1;
        clks(6);
        for (int i = 0; i < nclk; i++) begin
            MOSI = (i < n) ? fv[n-1-i] : 1'($urandom);
            clks(5);
            miso_obs[i] = m_miso;
            if (i == 0) oe_obs = m_oe;
            SCK = 1'b1;
            clks(5);
            SCK = 1'b0;
        end
        clks(5);
        en_obs = m_en;
        ssel = 1'b0;
        clks(8);
        complete = (nclk >= n);
        for (int i = aw + 1; i < n && i < nclk; i++) miso_exp[i] = dov[dw-1-(i-aw-1)];
        if (nclk >= aw) ra_m[s] = addr;
        if (nclk >= aw + 1) wnr_m[s] = wnr;
        if (complete) di_m[s] = data;
        chk("eoc_count", 32'(n_eoc - b_eoc), complete ? 32'd1 : 32'd0);
        chk("wr_count", 32'(n_wr - b_wr), (complete && wnr) ? 32'd1 : 32'd0);
        chk("wr_without_eoc", 32'(n_wr_alone - b_wa), 32'd0);
        chk("frmerr_count", 32'(n_ferr - b_ferr), complete ? 32'd0 : 32'd1);
        chk("rd_count", 32'(n_rd - b_rd), (nclk >= aw + 1) ? 32'd1 : 32'd0);
        chk("bc", {27'd0, m_bc}, complete ? 32'(n) : 32'(nclk));
        chk("di", {16'd0, m_di}, {16'd0, di_m[s]});
        chk("ra", {28'd0, m_ra}, {28'd0, ra_m[s]});
        chk("wnr", {31'd0, m_wnr}, {31'd0, wnr_m[s]});
        chk("en_in_frame", {31'd0, en_obs}, (nclk >= aw + 1) ? 32'd1 : 32'd0);
        chk("en_after", {31'd0, m_en}, 32'd0);
        chk("oe_in_frame", {31'd0, oe_obs}, 32'd1);
        chk("oe_after", {31'd0, m_oe}, 32'd0);
        chk("miso_bits", miso_obs, miso_exp);
    endtask

    initial begin
        int bb, bw, nn, s;
        Rst = 1'b1; ssel = 1'b0; SCK = 1'b0; MOSI = 1'b0; sel = 1'b0;
        for (int k = 0; k < 2; k++) begin
            di_m[k] = 16'd0; ra_m[k] = 4'd0; wnr_m[k] = 1'b0;
        end
        clks(4);
        chk("rst_bc_a", {27'd0, a_bc}, 32'd0);
        chk("rst_outs_a", {20'd0, a_di, a_ra, a_wnr}, 32'd0);
        chk("rst_strobes_a", {24'd0, a_miso, a_oe, a_en, a_rd, a_wr, a_eoc, a_ferr, 1'b0}, 32'd0);
        chk("rst_outs_b", {7'd0, b_bc, b_di, b_ra}, 32'd0);
        Rst = 1'b0;
        clks(4);

        frame(1'b0, 16, 4'd5, 1'b1, 16'h0A5C, 16'h0777);
        frame(1'b0, 16, 4'd2, 1'b0, 16'h0000, 16'h03C9);
        frame(1'b0, 9, 4'd6, 1'b1, 16'h0123, 16'h0456);
        frame(1'b0, 20, 4'd7, 1'b1, 16'h0F0F, 16'h0ACE);

        // Reset in the middle of a selected frame; the remainder must be ignored.
        sel = 1'b0;
        bb = n_eoc; bw = n_wr;
        ssel = 1'b1;
        clks(6);
        for (int i = 0; i < 16; i++) begin
            MOSI = 1'($urandom);
            if (i == 8) begin
                Rst = 1'b1;
                clks(2);
                Rst = 1'b0;
            end
            clks(5);
            SCK = 1'b1;
            clks(5);
            SCK = 1'b0;
        end
        clks(5);
        chk("rstmid_oe", {31'd0, m_oe}, 32'd0);
        chk("rstmid_bc", {27'd0, m_bc}, 32'd0);
        ssel = 1'b0;
        clks(8);
        chk("rstmid_eoc", 32'(n_eoc - bb), 32'd0);
        chk("rstmid_wr", 32'(n_wr - bw), 32'd0);
        chk("rstmid_di", {16'd0, m_di}, 32'd0);
        for (int k = 0; k < 2; k++) begin
            di_m[k] = 16'd0; ra_m[k] = 4'd0; wnr_m[k] = 1'b0;
        end
        frame(1'b0, 16, 4'd3, 1'b1, 16'h0B6D, 16'h0912);

        frame(1'b1, 21, 4'hB, 1'b1, 16'hBEEF, 16'h5A5A);
        frame(1'b1, 21, 4'h3, 1'b0, 16'h0000, 16'h1234);

        for (int k = 0; k < 10; k++) begin
            s = int'($urandom_range(0, 1));
            nn = (s != 0) ? 21 : 16;
            frame(s[0], int'($urandom_range(1, nn + 3)), 4'($urandom), 1'($urandom),
                  16'($urandom), 16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
